// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON state type and permutation-controller constants
package ascon_pack;

   // x0 is element 0, x4 is element 4
   typedef logic [4:0][63:0] type_state;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } type_perm_ctrl_fsm;

   localparam logic [3:0] LAST_ROUND    = 4'd11;
   localparam logic [3:0] FIRST_ROUND_A = 4'd0;
   localparam logic [3:0] FIRST_ROUND_B = 4'd6;

endpackage

// File: rtl/ascon_xor_end.sv
// rtl/ascon_xor_end.sv - conditional key XOR into x3/x4 after the last round
module ascon_xor_end
   import ascon_pack::*;
(
   input  type_state    state_i,
   input  logic [127:0] key_i,
   input  logic         en_i,
   output type_state    state_o
);

   always_comb begin
      state_o = state_i;
      if (en_i) begin
         state_o[3] = state_i[3] ^ key_i[127:64];
         state_o[4] = state_i[4] ^ key_i[63:0];
      end
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - round sequencer and state-XOR stage ahead of the ASCON permutation
// Optional abort input enabled by ASCON_PERM_CTRL_ABORT_EN.
module ascon_perm_ctrl
   import ascon_pack::*;
#(
   parameter int unsigned NB_ROUNDS_A = 12,
   parameter int unsigned NB_ROUNDS_B = 6
) (
   input  logic         clock_i,
   input  logic         resetb_i,
   input  logic         start_i,
   input  logic         mode_i,
   input  logic         xor_data_i,
   input  logic         xor_key_end_i,
`ifdef ASCON_PERM_CTRL_ABORT_EN
   input  logic         abort_i,
`endif
   input  type_state    state_i,
   input  logic [63:0]  data_i,
   input  logic [127:0] key_i,
   input  type_state    perm_state_i,
   output logic         select_o,
   output logic [3:0]   roundp_o,
   output type_state    perm_state_o,
   output logic [63:0]  cipher_o,
   output type_state    state_o,
   output logic         busy_o,
   output logic         done_o
);

   localparam logic [3:0] FIRST_A = 4'(12 - NB_ROUNDS_A);
   localparam logic [3:0] FIRST_B = 4'(12 - NB_ROUNDS_B);

   type_perm_ctrl_fsm state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        first_round;
   logic              mode_q;
   logic              xor_key_end_q;
   logic              accept;
   logic              complete;
   logic              abort;
   type_state         perm_begin;
   type_state         state_end;

`ifdef ASCON_PERM_CTRL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign first_round = mode_q ? FIRST_B : FIRST_A;

   always_comb begin
      perm_begin = state_i;
      if (xor_data_i) begin
         perm_begin[0] = state_i[0] ^ data_i;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      complete = 1'b0;
      select_o = 1'b0;
      roundp_o = 4'd0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               cnt_d   = mode_i ? FIRST_B : FIRST_A;
               state_d = RUN;
            end
         end
         RUN: begin
            roundp_o = cnt_q;
            // only the first round takes the freshly latched state; later rounds iterate
            select_o = (cnt_q == first_round);
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == LAST_ROUND) begin
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         FINISH: begin
            state_d = IDLE;
            if (!abort) begin
               complete = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   ascon_xor_end u_xor_end (
      .state_i (perm_state_i),
      .key_i   (key_i),
      .en_i    (xor_key_end_q),
      .state_o (state_end)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         mode_q        <= 1'b0;
         xor_key_end_q <= 1'b0;
         perm_state_o  <= '0;
         cipher_o      <= 64'd0;
         state_o       <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_o  <= (state_d != IDLE);
         done_o  <= complete;
         if (accept) begin
            mode_q        <= mode_i;
            xor_key_end_q <= xor_key_end_i;
            perm_state_o  <= perm_begin;
            cipher_o      <= state_i[0] ^ data_i;
         end
         if (complete) begin
            state_o <= state_end;
         end
      end
   end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - self-checking bench for ascon_perm_ctrl with behavioural model
module tb_ascon_perm_ctrl;
   import ascon_pack::*;

`ifdef ASCON_PERM_CTRL_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         resetb = 1'b1;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic         xor_data = 1'b0;
   logic         xor_key_end = 1'b0;
   logic         abort = 1'b0;
   type_state    state_in = '0;
   logic [63:0]  data = 64'd0;
   logic [127:0] key = 128'd0;
   type_state    perm_reg = '0;
   logic         select;
   logic [3:0]   roundp;
   type_state    perm_state;
   logic [63:0]  cipher;
   type_state    state_out;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ascon_perm_ctrl dut (
      .clock_i       (clock),
      .resetb_i      (resetb),
      .start_i       (start),
      .mode_i        (mode),
      .xor_data_i    (xor_data),
      .xor_key_end_i (xor_key_end),
`ifdef ASCON_PERM_CTRL_ABORT_EN
      .abort_i       (abort),
`endif
      .state_i       (state_in),
      .data_i        (data),
      .key_i         (key),
      .perm_state_i  (perm_reg),
      .select_o      (select),
      .roundp_o      (roundp),
      .perm_state_o  (perm_state),
      .cipher_o      (cipher),
      .state_o       (state_out),
      .busy_o        (busy),
      .done_o        (done)
   );

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One ASCON round: constant addition, 5-bit S-box, linear diffusion
   function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x2 = x2 ^ {56'd0, 4'(4'd15 - r), r};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return {x4, x3, x2, x1, x0};
   endfunction

   function automatic type_state rnd_state();
      type_state s;
      for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
      return s;
   endfunction

   // Permutation register downstream of the controller
   always @(posedge clock) perm_reg <= ascon_round(select ? perm_state : perm_reg, roundp);

   // Behavioural model: m_k counts edges since accept; rounds occupy m_k = 0..m_n-1
   bit         m_active = 1'b0;
   int         m_k = 0;
   int         m_n = 12;
   logic [3:0] m_first = 4'd0;
   bit         m_xke = 1'b0;
   type_state  m_perm = '0;
   type_state  m_res = '0;
   type_state  m_state = '0;
   logic [63:0] m_cipher = 64'd0;
   bit         m_busy = 1'b0;
   bit         m_done = 1'b0;

   always @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         m_active = 1'b0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
         m_perm = '0; m_state = '0; m_cipher = 64'd0;
      end else if (m_active) begin
         m_done = 1'b0;
         if (ABORT_EN && abort) begin
            m_active = 1'b0; m_busy = 1'b0;
         end else if (m_k == m_n) begin
            m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            m_state = m_res;
            if (m_xke) begin
               m_state[3] = m_state[3] ^ key[127:64];
               m_state[4] = m_state[4] ^ key[63:0];
            end
         end else begin
            m_k++;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_perm = state_in;
            if (xor_data) m_perm[0] = m_perm[0] ^ data;
            m_cipher = state_in[0] ^ data;
            m_n = mode ? 6 : 12;
            m_first = 4'(12 - m_n);
            m_res = m_perm;
            for (int r = 12 - m_n; r < 12; r++) m_res = ascon_round(m_res, 4'(r));
            m_xke = xor_key_end;
            m_k = 0; m_active = 1'b1; m_busy = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      bit e_run;
      e_run = m_active && (m_k < m_n);
      check("busy_o", 320'(busy), 320'(m_busy));
      check("done_o", 320'(done), 320'(m_done));
      check("select_o", 320'(select), 320'(e_run && m_k == 0));
      check("roundp_o", 320'(roundp), 320'(e_run ? m_first + 4'(m_k) : 4'd0));
      check("perm_state_o", perm_state, m_perm);
      check("cipher_o", 320'(cipher), 320'(m_cipher));
      check("state_o", state_out, m_state);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive a request, then scramble everything except the key to show it is latched
   task automatic start_op(input logic md, input logic xd, input logic xk,
                           input type_state s, input logic [63:0] d, input logic [127:0] k);
      mode = md; xor_data = xd; xor_key_end = xk; state_in = s; data = d; key = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode = 1'($urandom); xor_data = 1'($urandom); xor_key_end = 1'($urandom);
      state_in = rnd_state(); data = {$urandom, $urandom};
   endtask

   task automatic wait_done(input string name, input int exp_lat, input int already);
      int cyc;
      cyc = already;
      while (done !== 1'b1 && cyc < 64) begin
         tick();
         cyc++;
      end
      check(name, 320'(cyc), 320'(exp_lat));
   endtask

   initial begin
      type_state    s;
      logic [127:0] k;
      logic [127:0] n;
      type_state    prev;
      int           cnt_done;
      int           cnt_idle;
      int           guard;

      #1 resetb = 1'b0;
      tick(); tick();
      check("rst_busy", 320'(busy), 320'(0));
      check("rst_roundp", 320'(roundp), 320'(0));
      check("rst_state_o", state_out, 320'(0));
      resetb = 1'b1;
      tick();

      // reset in the middle of a p^a run
      start_op(1'b0, 1'b0, 1'b1, rnd_state(), {$urandom, $urandom}, {4{$urandom}});
      tick(); tick(); tick(); tick();
      resetb = 1'b0;
      #1;
      check("midrst_busy", 320'(busy), 320'(0));
      check("midrst_done", 320'(done), 320'(0));
      check("midrst_select", 320'(select), 320'(0));
      check("midrst_roundp", 320'(roundp), 320'(0));
      check("midrst_perm", perm_state, 320'(0));
      check("midrst_cipher", 320'(cipher), 320'(0));
      tick();
      resetb = 1'b1;
      cnt_done = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (done === 1'b1) cnt_done++;
      end
      check("midrst_no_done", 320'(cnt_done), 320'(0));
      check("midrst_busy_after", 320'(busy), 320'(0));

      // p^a on an ASCON-128 initialisation state with key XOR at the end
      k = 128'h000102030405060708090A0B0C0D0E0F;
      n = 128'h101112131415161718191A1B1C1D1E1F;
      s[0] = 64'h80400c0600000000; s[1] = k[127:64]; s[2] = k[63:0];
      s[3] = n[127:64]; s[4] = n[63:0];
      start_op(1'b0, 1'b0, 1'b1, s, 64'd0, k);
      check("init_perm_loaded", perm_state, s);
      for (int i = 0; i < 12; i++) begin
         check("init_roundp_seq", 320'(roundp), 320'(i));
         check("init_select_seq", 320'(select), 320'(i == 0));
         tick();
      end
      wait_done("init_latency_pa", 13, 12);
      tick();

      // p^b with data XOR into x0
      s = rnd_state();
      s[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      start_op(1'b1, 1'b1, 1'b0, s, 64'h0123456789ABCDEF, {4{$urandom}});
      check("pb_cipher", 320'(cipher), 320'(64'hFEDCBA9876543210));
      check("pb_perm_x0", 320'(perm_state[0]), 320'(64'hFEDCBA9876543210));
      check("pb_first_round", 320'(roundp), 320'(6));
      wait_done("pb_latency", 7, 0);
      tick();

      // start held high: back-to-back p^b runs
      mode = 1'b1; xor_data = 1'b0; xor_key_end = 1'b1;
      state_in = rnd_state(); key = {4{$urandom}};
      start = 1'b1;
      tick();
      cnt_done = 0; cnt_idle = 0;
      for (int i = 0; i < 24; i++) begin
         if (done === 1'b1) cnt_done++;
         if (busy === 1'b0) cnt_idle++;
         tick();
      end
      start = 1'b0;
      check("held_done_count", 320'(cnt_done), 320'(3));
      check("held_idle_count", 320'(cnt_idle), 320'(3));
      wait_done("held_drain", 7, 0);
      tick();

      // start pulses at rounds 3 and 9 are ignored
      start_op(1'b0, 1'b1, 1'b1, rnd_state(), {$urandom, $urandom}, {4{$urandom}});
      tick(); tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done("pulse_latency", 13, 10);
      cnt_done = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (done === 1'b1) cnt_done++;
      end
      check("pulse_single_done", 320'(cnt_done), 320'(0));
      check("pulse_busy_idle", 320'(busy), 320'(0));

`ifdef ASCON_PERM_CTRL_ABORT_EN
      prev = m_state;
      start_op(1'b0, 1'b0, 1'b1, rnd_state(), {$urandom, $urandom}, {4{$urandom}});
      tick(); tick(); tick(); tick();
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_busy", 320'(busy), 320'(0));
      check("abort_done", 320'(done), 320'(0));
      check("abort_state_kept", state_out, prev);
      start_op(1'b0, 1'b0, 1'b1, rnd_state(), {$urandom, $urandom}, {4{$urandom}});
      wait_done("abort_restart_latency", 13, 0);
      tick();
`else
      prev = '0;
`endif

      // randomized traffic checked every cycle by the model
      for (int i = 0; i < 700; i++) begin
         start = ($urandom_range(0, 3) == 0);
         mode = 1'($urandom); xor_data = 1'($urandom); xor_key_end = 1'($urandom);
         state_in = rnd_state(); data = {$urandom, $urandom};
         if (!m_active) key = {$urandom, $urandom, $urandom, $urandom};
         abort = ABORT_EN && ($urandom_range(0, 15) == 0);
         tick();
      end
      start = 1'b0; abort = 1'b0;
      guard = 0;
      while (m_active && guard < 40) begin
         tick();
         guard++;
      end
      check("random_drain", 320'(m_active), 320'(0));
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
